// File: rtl/wb_defs_pkg.sv
// Shared definitions for the register-file writeback path: widths,
// load funct3 encodings and the packed layouts of the two FIFO entry types.
package wb_defs;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;

    // rd sits in the MSBs of both entry types so hazard compare can slice it directly
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } alu_entry_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            addr_lo;
    } load_tag_t;

    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
               (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of the ALU/load/memory/decode/register-file signals around the
// writeback block. master = issuing pipeline side, slave = reg_writeback.
interface reg_writeback_if;
    import wb_defs::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;

    logic                  load_issue;
    logic [REG_ADDR_W-1:0] load_rd;
    logic [2:0]            load_funct3;
    logic [1:0]            load_addr_lo;
    logic                  load_ready;

    logic                  mem_rvalid;
    logic [XLEN-1:0]       mem_rdata;

    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic [REG_ADDR_W-1:0] chk_rd;
    logic                  hazard_stall;

    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_reg_write;
    logic                  wb_err;

    modport master (
        output alu_valid, alu_rd, alu_data, load_issue, load_rd, load_funct3, load_addr_lo,
               mem_rvalid, mem_rdata, chk_rs1, chk_rs2, chk_rd,
        input  alu_ready, load_ready, hazard_stall, wb_rd, wb_data, wb_reg_write, wb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, load_issue, load_rd, load_funct3, load_addr_lo,
               mem_rvalid, mem_rdata, chk_rs1, chk_rs2, chk_rd,
        output alu_ready, load_ready, hazard_stall, wb_rd, wb_data, wb_reg_write, wb_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO with one extra pointer bit for full/empty detection.
// Every slot's valid flag and contents are exported so the owner can
// search all pending entries (used for hazard detection).
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic                         full,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]  entry_data
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, occ;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    if (DEPTH > 1) begin : g_multi
        assign wr_idx = wr_ptr[IW-1:0];
        assign rd_idx = rd_ptr[IW-1:0];
        assign full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    end else begin : g_single
        assign wr_idx = '0;
        assign rd_idx = '0;
        assign full   = (wr_ptr != rd_ptr);
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign occ     = wr_ptr - rd_ptr;
    // a push into a full FIFO is fine when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_idx];

    // pointer update
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // storage; contents of empty slots are masked by entry_valid, so no reset
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_idx] <= wdata;
    end

    // slot i is live when its distance from the read slot is below occupancy
    always_comb begin
        logic [IW-1:0] offset;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = IW'(i) - rd_idx;
            entry_valid[i] = (PW'(offset) < occ);
            entry_data[i]  = mem[i];
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Sole writer of the register file. Load returns take the write port over
// buffered ALU results; every pending destination is visible to decode
// through hazard_stall.
module reg_writeback
    import wb_defs::*;
#(
    parameter int ALU_DEPTH  = 2,
    parameter int LOAD_DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    reg_writeback_if.slave bus
);
    localparam int ALU_W = $bits(alu_entry_t);
    localparam int TAG_W = $bits(load_tag_t);

    logic [ALU_W-1:0]                     alu_head_raw;
    logic [TAG_W-1:0]                     ld_head_raw;
    alu_entry_t                           alu_head;
    load_tag_t                            ld_head;
    logic                                 alu_push, alu_pop, alu_empty, alu_full;
    logic                                 ld_push, ld_pop, ld_empty, ld_full;
    logic [ALU_DEPTH-1:0]                 alu_ent_valid;
    logic [ALU_DEPTH-1:0][ALU_W-1:0]      alu_ent_data;
    logic [LOAD_DEPTH-1:0]                ld_ent_valid;
    logic [LOAD_DEPTH-1:0][TAG_W-1:0]     ld_ent_data;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       ld_ext;
    logic                  ld_illegal;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]       wb_data_q;
    logic                  wb_we_q, wb_err_q;
    logic [REG_ADDR_W-1:0] chk_reg [3];
    logic                  hazard;

    assign alu_head = alu_entry_t'(alu_head_raw);
    assign ld_head  = load_tag_t'(ld_head_raw);

    assign alu_push = bus.alu_valid && !alu_full;
    assign alu_pop  = !bus.mem_rvalid && !alu_empty;
    assign ld_push  = bus.load_issue;
    assign ld_pop   = bus.mem_rvalid && !ld_empty;

    assign bus.alu_ready  = !alu_full;
    assign bus.load_ready = !ld_full;

    wb_fifo #(.WIDTH(ALU_W), .DEPTH(ALU_DEPTH)) u_alu_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (alu_push),
        .pop         (alu_pop),
        .wdata       ({bus.alu_rd, bus.alu_data}),
        .head        (alu_head_raw),
        .empty       (alu_empty),
        .full        (alu_full),
        .entry_valid (alu_ent_valid),
        .entry_data  (alu_ent_data)
    );

    wb_fifo #(.WIDTH(TAG_W), .DEPTH(LOAD_DEPTH)) u_load_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (ld_push),
        .pop         (ld_pop),
        .wdata       ({bus.load_rd, bus.load_funct3, bus.load_addr_lo}),
        .head        (ld_head_raw),
        .empty       (ld_empty),
        .full        (ld_full),
        .entry_valid (ld_ent_valid),
        .entry_data  (ld_ent_data)
    );

    // select and extend the returning word according to the oldest load tag
    always_comb begin
        ld_byte    = bus.mem_rdata[{ld_head.addr_lo, 3'b000} +: 8];
        ld_half    = bus.mem_rdata[{ld_head.addr_lo[1], 4'b0000} +: 16];
        ld_illegal = !funct3_legal(ld_head.funct3);
        case (ld_head.funct3)
            FUNCT3_LB:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            FUNCT3_LH:  ld_ext = {{16{ld_half[15]}}, ld_half};
            FUNCT3_LBU: ld_ext = {24'd0, ld_byte};
            FUNCT3_LHU: ld_ext = {16'd0, ld_half};
            default:    ld_ext = bus.mem_rdata;
        endcase
    end

    // write-port register: load return first, then ALU head, else idle
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_err_q  <= 1'b0;
        end else if (bus.mem_rvalid) begin
            if (ld_empty) begin
                wb_we_q  <= 1'b0;
                wb_err_q <= 1'b1;
            end else begin
                wb_rd_q   <= ld_head.rd;
                wb_data_q <= ld_ext;
                wb_we_q   <= (ld_head.rd != '0);
                if (ld_illegal) wb_err_q <= 1'b1;
            end
        end else if (!alu_empty) begin
            wb_rd_q   <= alu_head.rd;
            wb_data_q <= alu_head.data;
            wb_we_q   <= (alu_head.rd != '0);
        end else begin
            wb_we_q <= 1'b0;
        end
    end

    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_reg_write = wb_we_q;
    assign bus.wb_err       = wb_err_q;

    // stall decode when any nonzero operand/dest is still owed a write
    always_comb begin
        chk_reg[0] = bus.chk_rs1;
        chk_reg[1] = bus.chk_rs2;
        chk_reg[2] = bus.chk_rd;
        hazard     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (chk_reg[k] != '0) begin
                if (wb_we_q && (wb_rd_q == chk_reg[k])) hazard = 1'b1;
                for (int i = 0; i < ALU_DEPTH; i++) begin
                    if (alu_ent_valid[i] && (alu_ent_data[i][ALU_W-1 -: REG_ADDR_W] == chk_reg[k]))
                        hazard = 1'b1;
                end
                for (int i = 0; i < LOAD_DEPTH; i++) begin
                    if (ld_ent_valid[i] && (ld_ent_data[i][TAG_W-1 -: REG_ADDR_W] == chk_reg[k]))
                        hazard = 1'b1;
                end
            end
        end
    end

    assign bus.hazard_stall = hazard;

endmodule
